seven_seg_scan: RTL and testbench

Time-multiplexed driver for a common-anode/common-cathode multi-digit 7-segment display. It sits directly downstream of the per-digit 7-segment decoders. It takes their active-high segment patterns for every digit, latches them tear-free once per frame, and scans them onto a shared segment bus with one anode enable at a time. Dead-time blanking between slots suppresses ghosting.

---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/scan_timer.sv | 58 +++++
 rtl/seven_seg_scan.sv | 97 +++++++++
 tb/tb_seven_seg_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display driver.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    function automatic seg_t seg_polarity(input seg_t s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

    function automatic logic bit_polarity(input logic b, input bit active_low);
        return b ^ active_low;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/digit counters for the display scan, with end-of-frame strobe
// and the flag marking the lit part of a slot.
module scan_timer
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIGIT_CYCLES = 12500,
    parameter int BLANK_CYCLES = 64,
    parameter int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             eof_o,
    output logic             lit_win_o
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end;

    assign slot_end = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o     = idx_q;
    assign eof_o     = en_i && slot_end && (idx_q == IDX_LAST);
    assign lit_win_o = (cnt_q >= CNT_BLANK);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment driver: tear-free shadow latch per frame,
// digit mux, output polarity and registered outputs.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIGIT_CYCLES   = 12500,
    parameter int BLANK_CYCLES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [N_DIGITS*SEG_W-1:0] seg_i,
    input  logic [N_DIGITS-1:0]       dp_i,
    input  logic [N_DIGITS-1:0]       blank_i,
    output logic [SEG_W-1:0]          seg_o,
    output logic                      dp_o,
    output logic [N_DIGITS-1:0]       an_o,
    output logic                      frame_o
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};
    localparam seg_t SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

    if (N_DIGITS < 1 || BLANK_CYCLES < 0 ||
        BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_param
        $error("seven_seg_scan: illegal parameter set");
    end

    logic [IDX_W-1:0] idx;
    logic             eof, lit_win, load, lit;

    scan_timer #(
        .N_DIGITS    (N_DIGITS),
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en),
        .idx_o    (idx),
        .eof_o    (eof),
        .lit_win_o(lit_win)
    );

    logic [N_DIGITS*SEG_W-1:0] sh_seg_q, sh_seg_d;
    logic [N_DIGITS-1:0]       sh_dp_q, sh_dp_d;
    logic [N_DIGITS-1:0]       sh_blank_q, sh_blank_d;

    // Shadow follows inputs while idle, otherwise only at frame end
    assign load       = !en || eof;
    assign sh_seg_d   = load ? seg_i   : sh_seg_q;
    assign sh_dp_d    = load ? dp_i    : sh_dp_q;
    assign sh_blank_d = load ? blank_i : sh_blank_q;

    seg_t                cur_seg;
    logic [N_DIGITS-1:0] onehot;
    seg_t                seg_d;
    logic                dp_d, frame_d;
    logic [N_DIGITS-1:0] an_d;

    always_comb begin
        cur_seg     = sh_seg_q[SEG_W*int'(idx) +: SEG_W];
        lit         = en && lit_win && !sh_blank_q[idx];
        onehot      = '0;
        onehot[idx] = 1'b1;
        an_d        = (lit ? onehot : '0) ^ AN_OFF;
        seg_d       = seg_polarity(lit ? cur_seg : '0, SEG_ACTIVE_LOW);
        dp_d        = bit_polarity(lit && sh_dp_q[idx], SEG_ACTIVE_LOW);
        frame_d     = eof;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_seg_q   <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            an_o       <= AN_OFF;
            seg_o      <= SEG_OFF;
            dp_o       <= SEG_ACTIVE_LOW;
            frame_o    <= 1'b0;
        end else begin
            sh_seg_q   <= sh_seg_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            an_o       <= an_d;
            seg_o      <= seg_d;
            dp_o       <= dp_d;
            frame_o    <= frame_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: frame-position reference model
// feeds an expectation queue drained by an independent output monitor.
module tb_seven_seg_scan;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FR = N * DC;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [N*7-1:0] seg_i = '0;
    logic [N-1:0]   dp_i = '0;
    logic [N-1:0]   blank_i = '0;
    logic [6:0]     seg_o;
    logic           dp_o;
    logic [N-1:0]   an_o;
    logic           frame_o;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         fr;
    } exp_t;

    exp_t       q[$];
    int         errs = 0;
    int         checks = 0;
    logic [6:0] m_seg[N];
    logic       m_dp[N];
    logic       m_blank[N];
    int         pos = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .seg_i(seg_i), .dp_i(dp_i), .blank_i(blank_i),
        .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
    );

    task automatic snap();
        for (int k = 0; k < N; k++) begin
            m_seg[k]   = seg_i[7*k +: 7];
            m_dp[k]    = dp_i[k];
            m_blank[k] = blank_i[k];
        end
    endtask

    task automatic model_reset();
        pos = 0;
        for (int k = 0; k < N; k++) begin
            m_seg[k] = '0; m_dp[k] = 1'b0; m_blank[k] = 1'b0;
        end
        q.delete();
    endtask

    // Expected output for the cycle after this edge, from frame position
    task automatic model_step();
        exp_t         e;
        int           d, w;
        bit           lit;
        logic [N-1:0] one;
        one = 1;
        e = '{an: '1, seg: 7'h7F, dp: 1'b1, fr: 1'b0};
        if (!en) begin
            snap();
            pos = 0;
        end else begin
            d   = pos / DC;
            w   = pos % DC;
            lit = (w >= BC) && !m_blank[d];
            if (lit) begin
                e.an  = ~(one << d);
                e.seg = ~m_seg[d];
                e.dp  = ~m_dp[d];
            end
            e.fr = (pos == FR - 1);
            if (pos == FR - 1) snap();
            pos = (pos + 1) % FR;
        end
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        exp_t got;
        got = '{an: an_o, seg: seg_o, dp: dp_o, fr: frame_o};
        checks++;
        if (got !== exp_t'({{N{1'b1}}, 7'h7F, 1'b1, 1'b0})) begin
            errs++;
            $display("FAIL %s: got an=%b seg=%h dp=%b fr=%b, need idle", name, an_o, seg_o, dp_o, frame_o);
        end
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 2 * FR && pos != p; i++) step();
        checks++;
        if (pos != p) begin
            errs++;
            $display("FAIL run_to: pos=%0d, need %0d", pos, p);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e, got;
        if (rst_n && q.size() > 0) begin
            e   = q.pop_front();
            got = '{an: an_o, seg: seg_o, dp: dp_o, fr: frame_o};
            checks++;
            if (got !== e) begin
                errs++;
                $display("FAIL scan @%0t: got an=%b seg=%h dp=%b fr=%b, need an=%b seg=%h dp=%b fr=%b",
                         $time, got.an, got.seg, got.dp, got.fr, e.an, e.seg, e.dp, e.fr);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) step();
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) step();
        check_idle("idle_en0");

        seg_i = {7'h06, 7'h5B, 7'h4F, 7'h66};
        step();
        en = 1'b1;
        repeat (FR) step();
        run_to(10);
        seg_i = {7'h3F, 7'h6D, 7'h7D, 7'h07};
        repeat (2 * FR) step();

        blank_i = 4'b0100;
        dp_i    = 4'b0001;
        run_to(0);
        repeat (2 * FR) step();

        blank_i = '0;
        run_to(2 * DC + 5);
        en = 1'b0;
        step();
        check_idle("en_drop");
        repeat (2) step();
        en = 1'b1;
        repeat (FR + 8) step();

        run_to(20);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        model_reset();
        step();
        step();
        check_idle("rst_hold");
        rst_n = 1'b1;
        repeat (FR + 8) step();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) seg_i = 28'($urandom);
            if ($urandom_range(0, 31) == 0) dp_i = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blank_i = 4'($urandom);
            if (en && $urandom_range(0, 99) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            step();
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d left, need 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
